// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: shared state, redirect-source encodings and PC step for the fetch PC controller
package pc_ctrl_pkg;
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
   typedef enum logic [1:0] {SEQ = 2'd0, HOLD = 2'd1, ID_JMP = 2'd2, EX_BR = 2'd3} src_t;
   localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: pipeline-side hazard/jump inputs and fetch/flush outputs of the PC controller
interface pc_redirect_ctrl_if #(parameter int unsigned CNT_W = 16);
   logic             imem_ready;
   logic             stall_ID;
   logic             jal_ID;
   logic             jalr_ID;
   logic [31:0]      target_ID;
   logic             B_JUMP_EX;
   logic [31:0]      target_EX;
   logic [31:0]      pc_IF;
   logic             fetch_valid;
   logic             stall_IF_ID;
   logic             flush_IF_ID;
   logic             flush_ID_EX;
   logic             misalign_err;
   logic [CNT_W-1:0] redirect_count;
   modport master (
      output imem_ready, stall_ID, jal_ID, jalr_ID, target_ID, B_JUMP_EX, target_EX,
      input  pc_IF, fetch_valid, stall_IF_ID, flush_IF_ID, flush_ID_EX, misalign_err, redirect_count
   );
   modport slave (
      input  imem_ready, stall_ID, jal_ID, jalr_ID, target_ID, B_JUMP_EX, target_EX,
      output pc_IF, fetch_valid, stall_IF_ID, flush_IF_ID, flush_ID_EX, misalign_err, redirect_count
   );
endinterface

// File: rtl/pc_redirect_ctrl_target_sel.sv
// pc_target_sel: per-cycle redirect arbitration, EX branch beats ID jump beats stall beats sequential
module pc_target_sel
   import pc_ctrl_pkg::*;
(
   input  logic        i_imem_ready,
   input  logic        i_stall_ID,
   input  logic        i_jal_ID,
   input  logic        i_jalr_ID,
   input  logic [31:0] i_target_ID,
   input  logic        i_B_JUMP_EX,
   input  logic [31:0] i_target_EX,
   output src_t        o_src,
   output logic [31:0] o_target,
   output logic        o_misalign
);
   always_comb begin
      o_src      = i_B_JUMP_EX ? EX_BR :
                   ((i_jal_ID | i_jalr_ID) & !i_stall_ID) ? ID_JMP :
                   (i_stall_ID | !i_imem_ready) ? HOLD : SEQ;
      o_target   = i_B_JUMP_EX ? i_target_EX : i_target_ID;
      o_misalign = (o_src == EX_BR || o_src == ID_JMP) && o_target[1:0] != 2'b00;
   end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC register, boot hold-off, redirect/stall/flush control and redirect counter
module pc_redirect_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BOOT_WAIT = 2,
   parameter int unsigned CNT_W     = 16
) (
   input logic              clk,
   input logic              rst,
   pc_redirect_ctrl_if.slave bus
);
   state_t           r_state, w_next;
   src_t             w_src;
   logic [31:0]      r_pc, r_boot_cnt, w_target;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mis, w_mis, w_run, w_redir, w_boot_done;
   pc_target_sel u_sel (
      .i_imem_ready (bus.imem_ready),
      .i_stall_ID   (bus.stall_ID),
      .i_jal_ID     (bus.jal_ID),
      .i_jalr_ID    (bus.jalr_ID),
      .i_target_ID  (bus.target_ID),
      .i_B_JUMP_EX  (bus.B_JUMP_EX),
      .i_target_EX  (bus.target_EX),
      .o_src        (w_src),
      .o_target     (w_target),
      .o_misalign   (w_mis)
   );
   assign w_run       = r_state == RUN;
   assign w_redir     = w_src == EX_BR || w_src == ID_JMP;
   assign w_boot_done = (r_boot_cnt + 32'd1) >= BOOT_WAIT;
   always_ff @(posedge clk) begin
      if (rst) r_state <= BOOT;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == BOOT && w_boot_done) ? RUN :
               (w_run && w_redir && w_mis) ? HALT : r_state;
   end
   always_comb begin
      bus.fetch_valid = w_run;
      bus.stall_IF_ID = w_run && w_src == HOLD && bus.stall_ID;
      bus.flush_IF_ID = w_run && w_redir;
      bus.flush_ID_EX = w_run && w_src == EX_BR;
   end
   // A misaligned redirect still flushes but leaves the PC and counter untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_boot_cnt <= '0;
         r_mis      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (r_state == BOOT) r_boot_cnt <= r_boot_cnt + 32'd1;
         if (w_run && w_redir && w_mis) r_mis <= 1'b1;
         if (w_run) r_pc <= (w_redir && !w_mis) ? w_target : (w_src == SEQ) ? r_pc + PC_STEP : r_pc;
         if (w_run && w_redir && !w_mis && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
   end
   assign bus.pc_IF          = r_pc;
   assign bus.misalign_err   = r_mis;
   assign bus.redirect_count = r_cnt;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vector table plus boot, halt and counter-saturation sequences
module tb_pc_redirect_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   pc_redirect_ctrl_if #(.CNT_W(16)) bus ();
   pc_redirect_ctrl_if #(.CNT_W(2))  bus2 ();
   pc_redirect_ctrl #(.RESET_PC(32'h0), .BOOT_WAIT(2), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   pc_redirect_ctrl #(.RESET_PC(32'h0), .BOOT_WAIT(0), .CNT_W(2))  u_sat (.clk(clk), .rst(rst2), .bus(bus2));
   typedef struct {
      logic        rdy, stl, jal, jalr, br;
      logic [31:0] tid, tex;
      logic        e_stl, e_fif, e_fie;
      logic [31:0] e_pc;
      logic [15:0] e_cnt;
   } vec_t;
   vec_t tv[13];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic rdy, stl, jal, jalr, br, input logic [31:0] tid, tex);
      bus.imem_ready = rdy;
      bus.stall_ID   = stl;
      bus.jal_ID     = jal;
      bus.jalr_ID    = jalr;
      bus.B_JUMP_EX  = br;
      bus.target_ID  = tid;
      bus.target_EX  = tex;
   endtask
   initial begin
      tv[0]  = '{1,0,0,0,0,32'h0,32'h0,       0,0,0,32'h4,16'd0};
      tv[1]  = '{1,0,0,0,0,32'h0,32'h0,       0,0,0,32'h8,16'd0};
      tv[2]  = '{0,0,0,0,0,32'h0,32'h0,       0,0,0,32'h8,16'd0};
      tv[3]  = '{0,0,1,0,0,32'h100,32'h0,     0,1,0,32'h100,16'd1};
      tv[4]  = '{1,0,1,0,1,32'h200,32'h40,    0,1,1,32'h40,16'd2};
      tv[5]  = '{1,1,0,1,0,32'h80,32'h0,      1,0,0,32'h40,16'd2};
      tv[6]  = '{1,1,0,1,0,32'h80,32'h0,      1,0,0,32'h40,16'd2};
      tv[7]  = '{0,0,0,1,0,32'h80,32'h0,      0,1,0,32'h80,16'd3};
      tv[8]  = '{1,1,0,0,0,32'h0,32'h0,       1,0,0,32'h80,16'd3};
      tv[9]  = '{0,0,1,0,0,32'hFFFFFFFC,32'h0,0,1,0,32'hFFFFFFFC,16'd4};
      tv[10] = '{1,0,0,0,0,32'h0,32'h0,       0,0,0,32'h0,16'd4};
      tv[11] = '{0,0,0,0,0,32'h0,32'h0,       0,0,0,32'h0,16'd4};
      tv[12] = '{1,1,0,0,1,32'h0,32'h10,      0,1,1,32'h10,16'd5};
      bus2.imem_ready = 1'b1;
      bus2.stall_ID   = 1'b0;
      bus2.jal_ID     = 1'b0;
      bus2.jalr_ID    = 1'b0;
      bus2.B_JUMP_EX  = 1'b0;
      bus2.target_ID  = 32'h0;
      bus2.target_EX  = 32'h0;
      drive(1, 0, 0, 0, 1, 32'h0, 32'h40);
      tick();
      tick();
      chk("rst_pc", bus.pc_IF, 32'h0);
      chk("rst_fv", 32'(bus.fetch_valid), 32'd0);
      chk("rst_flush", 32'(bus.flush_IF_ID), 32'd0);
      chk("rst_mis", 32'(bus.misalign_err), 32'd0);
      chk("rst_cnt", 32'(bus.redirect_count), 32'd0);
      rst = 1'b0;
      #4;
      chk("boot0_fv", 32'(bus.fetch_valid), 32'd0);
      chk("boot0_flush", {30'd0, bus.flush_IF_ID, bus.flush_ID_EX}, 32'd0);
      tick();
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
      chk("boot1_fv", 32'(bus.fetch_valid), 32'd0);
      chk("boot1_pc", bus.pc_IF, 32'h0);
      tick();
      chk("run_fv", 32'(bus.fetch_valid), 32'd1);
      chk("run_pc0", bus.pc_IF, 32'h0);
      for (int i = 0; i < 13; i++) begin
         drive(tv[i].rdy, tv[i].stl, tv[i].jal, tv[i].jalr, tv[i].br, tv[i].tid, tv[i].tex);
         #4;
         chk($sformatf("v%0d_stall", i), 32'(bus.stall_IF_ID), 32'(tv[i].e_stl));
         chk($sformatf("v%0d_fif", i), 32'(bus.flush_IF_ID), 32'(tv[i].e_fif));
         chk($sformatf("v%0d_fie", i), 32'(bus.flush_ID_EX), 32'(tv[i].e_fie));
         tick();
         chk($sformatf("v%0d_pc", i), bus.pc_IF, tv[i].e_pc);
         chk($sformatf("v%0d_cnt", i), 32'(bus.redirect_count), 32'(tv[i].e_cnt));
      end
      drive(1, 0, 0, 0, 1, 32'h0, 32'h102);
      #4;
      chk("mis_fif", 32'(bus.flush_IF_ID), 32'd1);
      chk("mis_fie", 32'(bus.flush_ID_EX), 32'd1);
      tick();
      chk("mis_err", 32'(bus.misalign_err), 32'd1);
      chk("mis_fv", 32'(bus.fetch_valid), 32'd0);
      chk("mis_pc", bus.pc_IF, 32'h10);
      chk("mis_cnt", 32'(bus.redirect_count), 32'd5);
      drive(1, 1, 1, 0, 0, 32'h200, 32'h0);
      #4;
      chk("halt_flush", {30'd0, bus.flush_IF_ID, bus.stall_IF_ID}, 32'd0);
      tick();
      chk("halt_pc", bus.pc_IF, 32'h10);
      chk("halt_err", 32'(bus.misalign_err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rerst_pc", bus.pc_IF, 32'h0);
      chk("rerst_err", 32'(bus.misalign_err), 32'd0);
      chk("rerst_cnt", 32'(bus.redirect_count), 32'd0);
      chk("rerst_fv", 32'(bus.fetch_valid), 32'd0);
      tick();
      rst2 = 1'b0;
      bus2.jal_ID = 1'b1;
      bus2.target_ID = 32'h8;
      tick();
      chk("sat_fv", 32'(bus2.fetch_valid), 32'd1);
      chk("sat_cnt0", 32'(bus2.redirect_count), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         bus2.target_ID = 32'(k * 16);
         tick();
         chk($sformatf("sat_pc%0d", k), bus2.pc_IF, 32'(k * 16));
         chk($sformatf("sat_cnt%0d", k), 32'(bus2.redirect_count), (k < 3) ? 32'(k) : 32'd3);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
